instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 69 ++++++
 rtl/instr_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-path types: datapath width, default boot address, fetch FSM
// state encoding and the instruction-buffer entry layout.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Fixed encodings so waveforms and older scripts keep matching.
    typedef enum logic [1:0] {
        FS_REQ  = 2'b00,  // free to issue a request
        FS_WAIT = 2'b01,  // one request granted, data still to come
        FS_DROP = 2'b10   // data still to come, but it is stale
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between the fetch FSM and decode.
// Ports:
//   clk, rst          clock, async active-high reset
//   flush             drop every entry (wins over push/pop)
//   push, push_data   write one {pc, instr} entry at the tail
//   pop               retire the head entry
//   head              entry at the head (stale when empty)
//   full, empty       occupancy flags
//   count             current occupancy, 0..DEPTH
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok;
    logic          pop_ok;

    // Guarded handshakes: the buffer never corrupts itself on misuse.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage is reset so the head reads as zero straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues one word read at a time to instruction
// memory, buffers returned words with their PC, and handles redirects by
// flushing the buffer and discarding any in-flight response.
// Ports:
//   clk, rst                         clock, async active-high reset
//   redirect_valid, redirect_pc      taken branch/jump and its target
//   imem_req, imem_addr              read request and word-aligned address
//   imem_gnt                         memory accepts the request this cycle
//   imem_rvalid, imem_rdata          read response
//   out_valid, out_instr, out_pc     buffer head towards decode
//   out_ready                        decode consumes the head this cycle
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            out_valid,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    input  logic            out_ready
);

    localparam int unsigned     CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    fetch_state_e    state_q;
    fetch_state_e    state_nxt;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] fetch_pc_nxt;
    logic [XLEN-1:0] req_pc_q;
    logic [XLEN-1:0] req_pc_nxt;
    logic            req_q;
    logic            req_nxt;
    logic            grant_c;
    logic            push_c;
    logic            pop_c;
    logic            flush_c;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic            full;
    logic            empty;
    fetch_entry_t    push_data;
    fetch_entry_t    head;

    // Next state, fetch PC and buffer controls; redirect overrides everything.
    always_comb begin
        state_nxt    = state_q;
        fetch_pc_nxt = fetch_pc_q;
        req_pc_nxt   = req_pc_q;
        push_c       = 1'b0;
        flush_c      = redirect_valid;
        grant_c      = req_q && imem_gnt && !full;
        pop_c        = !empty && out_ready && !redirect_valid;

        case (state_q)
            FS_REQ: begin
                // A granted request is owed a response even if we redirect.
                if (grant_c) begin
                    state_nxt    = redirect_valid ? FS_DROP : FS_WAIT;
                    req_pc_nxt   = fetch_pc_q;
                    fetch_pc_nxt = fetch_pc_q + PC_STEP;
                end
            end
            FS_WAIT: begin
                if (imem_rvalid) begin
                    state_nxt = FS_REQ;
                    push_c    = !redirect_valid;
                end else if (redirect_valid) begin
                    state_nxt = FS_DROP;
                end
            end
            FS_DROP: begin
                if (imem_rvalid) begin
                    state_nxt = FS_REQ;
                end
            end
            default: begin
                state_nxt = FS_REQ;
            end
        endcase

        if (redirect_valid) begin
            fetch_pc_nxt = redirect_pc & ALIGN_MASK;
        end

        if (flush_c) begin
            count_nxt = '0;
        end else begin
            count_nxt = count + CW'(push_c) - CW'(pop_c);
        end

        // Requesting only with a free slot reserves space for the response.
        req_nxt = (state_nxt == FS_REQ) && (count_nxt < CW'(FIFO_DEPTH));
    end

    // State and request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FS_REQ;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            fetch_pc_q <= fetch_pc_nxt;
            req_pc_q   <= req_pc_nxt;
            req_q      <= req_nxt;
        end
    end

    assign push_data = '{pc: req_pc_q, instr: imem_rdata};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush_c),
        .push      (push_c),
        .push_data (push_data),
        .pop       (pop_c),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign imem_req  = req_q;
    assign imem_addr = fetch_pc_q;
    assign out_valid = !empty;
    assign out_instr = head.instr;
    assign out_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a fixed vector table for the straight-line
// fetch stream, directed sequences for stall, redirect, reset and wrap cases,
// and a randomized run checked against a queue-based reference model.
module tb_instr_fetch_unit;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC   (RPC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    typedef struct {
        bit          gnt;
        bit          rv;
        logic [31:0] rdata;
        bit          rdy;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
    } vec_t;

    // Memory responder state.
    bit          pend;
    int          pend_cnt;
    logic [31:0] pend_addr;
    int          lat;
    bit          rand_lat;
    int          gnt_pct;

    // Reference model state: expected buffer contents and fetch progress.
    ent_t        m_buf[$];
    bit          m_out;
    bit          m_drop;
    bit          m_hold;
    logic [31:0] m_pc;
    logic [31:0] m_opc;

    ent_t        pops[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h00C0_FFEE;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_buf.delete();
        m_out  = 1'b0;
        m_drop = 1'b0;
        m_hold = 1'b1;
        m_pc   = RPC;
    endtask

    // One clock of the fetch rules, given this cycle's inputs.
    task automatic model_step(input bit red, input logic [31:0] rpc, input bit gnt,
                              input bit rv, input bit rdy);
        bit req_m;
        req_m  = !m_hold && !m_out && (m_buf.size() < DEPTH);
        m_hold = 1'b0;
        if (red) begin
            m_buf.delete();
            if (req_m && gnt) begin
                m_out  = 1'b1;
                m_drop = 1'b1;
            end else if (m_out && rv) begin
                m_out = 1'b0;
            end else if (m_out) begin
                m_drop = 1'b1;
            end
            m_pc = rpc & 32'hFFFF_FFFC;
        end else begin
            if (m_buf.size() != 0 && rdy) void'(m_buf.pop_front());
            if (m_out && rv) begin
                if (!m_drop) m_buf.push_back('{m_opc, mem_word(m_opc)});
                m_out = 1'b0;
            end
            if (req_m && gnt) begin
                m_out  = 1'b1;
                m_drop = 1'b0;
                m_opc  = m_pc;
                m_pc   = m_pc + 32'd4;
            end
        end
    endtask

    task automatic model_check(input int cyc);
        bit req_m;
        req_m = !m_hold && !m_out && (m_buf.size() < DEPTH);
        check($sformatf("rand c%0d imem_req", cyc), imem_req, req_m);
        if (req_m) check($sformatf("rand c%0d imem_addr", cyc), imem_addr, m_pc);
        check($sformatf("rand c%0d out_valid", cyc), out_valid, m_buf.size() != 0);
        if (m_buf.size() != 0) begin
            check($sformatf("rand c%0d out_pc", cyc), out_pc, m_buf[0].pc);
            check($sformatf("rand c%0d out_instr", cyc), out_instr, m_buf[0].instr);
        end
    endtask

    // Drive one cycle: memory responder, decode side, redirect; then the edge.
    task automatic drive_cycle(input bit rdy, input bit red, input logic [31:0] rpc);
        bit          gnt;
        bit          granted;
        logic [31:0] gaddr;
        gnt            = ($urandom_range(99) < gnt_pct);
        imem_gnt       = gnt;
        imem_rvalid    = pend && (pend_cnt == 0);
        imem_rdata     = imem_rvalid ? mem_word(pend_addr) : 32'hDEAD_BEEF;
        out_ready      = rdy;
        redirect_valid = red;
        redirect_pc    = rpc;
        granted        = imem_req && gnt;
        gaddr          = imem_addr;
        if (out_valid && rdy && !red && !rst) pops.push_back('{out_pc, out_instr});
        if (rst) model_reset();
        else model_step(red, rpc, gnt, imem_rvalid, rdy);
        @(posedge clk);
        #1;
        if (imem_rvalid) pend = 1'b0;
        else if (pend && pend_cnt > 0) pend_cnt--;
        if (granted) begin
            pend      = 1'b1;
            pend_cnt  = (rand_lat ? int'($urandom_range(3, 1)) : lat) - 1;
            pend_addr = gaddr;
        end
    endtask

    task automatic start_reset();
        rst            = 1'b1;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        pend           = 1'b0;
        pend_cnt       = 0;
        pend_addr      = '0;
        lat            = 1;
        rand_lat       = 1'b0;
        gnt_pct        = 100;
        pops.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input bit gnt, input bit rv, input logic [31:0] rdata,
                                input bit e_req, input logic [31:0] e_addr,
                                input bit e_valid, input logic [31:0] e_pc);
        vec_t v;
        v.gnt = gnt;  v.rv = rv;  v.rdata = rdata;  v.rdy = 1'b1;
        v.e_req = e_req;  v.e_addr = e_addr;  v.e_valid = e_valid;  v.e_pc = e_pc;
        return v;
    endfunction

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : main
        vec_t        vecs[9];
        bit          done;
        bit          got;
        bit          seen;
        bit          r;
        bit          rvnow;
        bit          fresh;
        bit          rdy;
        logic [31:0] rpc;

        // Straight-line stream from reset; row 0 also shows rvalid ignored in REQ.
        vecs[0] = mk(1, 1, 32'h1234_5678, 1, 32'h00, 0, 32'h0);
        vecs[1] = mk(1, 0, 32'h0,         0, 32'h04, 0, 32'h0);
        vecs[2] = mk(1, 1, mem_word(0),   1, 32'h04, 1, 32'h0);
        vecs[3] = mk(1, 0, 32'h0,         0, 32'h08, 0, 32'h0);
        vecs[4] = mk(1, 1, mem_word(4),   1, 32'h08, 1, 32'h4);
        vecs[5] = mk(1, 0, 32'h0,         0, 32'h0C, 0, 32'h0);
        vecs[6] = mk(1, 1, mem_word(8),   1, 32'h0C, 1, 32'h8);
        vecs[7] = mk(1, 0, 32'h0,         0, 32'h10, 0, 32'h0);
        vecs[8] = mk(1, 1, mem_word(12),  1, 32'h10, 1, 32'hC);

        start_reset();
        check("reset imem_req", imem_req, 0);
        check("reset imem_addr", imem_addr, RPC);
        check("reset out_valid", out_valid, 0);
        check("reset out_pc", out_pc, 0);
        check("reset out_instr", out_instr, 0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            imem_gnt    = vecs[i].gnt;
            imem_rvalid = vecs[i].rv;
            imem_rdata  = vecs[i].rdata;
            out_ready   = vecs[i].rdy;
            @(posedge clk);
            #1;
            check($sformatf("row%0d imem_req", i), imem_req, vecs[i].e_req);
            check($sformatf("row%0d imem_addr", i), imem_addr, vecs[i].e_addr);
            check($sformatf("row%0d out_valid", i), out_valid, vecs[i].e_valid);
            if (vecs[i].e_valid) begin
                check($sformatf("row%0d out_pc", i), out_pc, vecs[i].e_pc);
                check($sformatf("row%0d out_instr", i), out_instr, mem_word(vecs[i].e_pc));
            end
        end

        // Decode stalled: buffer fills, requests stop, head holds.
        start_reset();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            drive_cycle(1'b0, 1'b0, 32'h0);
            if (c >= 2) check($sformatf("stall c%0d out_pc", c), out_pc, 32'h0);
        end
        check("stall out_valid", out_valid, 1);
        check("stall out_instr", out_instr, mem_word(0));
        check("stall imem_req", imem_req, 0);
        pops.delete();
        for (int c = 0; c < 12; c++) drive_cycle(1'b1, 1'b0, 32'h0);
        check("stall pop count", pops.size() >= 4, 1);
        for (int i = 0; i < 4; i++) begin
            if (i < pops.size()) begin
                check($sformatf("stall pop%0d pc", i), pops[i].pc, 32'(i * 4));
                check($sformatf("stall pop%0d instr", i), pops[i].instr, mem_word(32'(i * 4)));
            end
        end

        // Redirect in the same cycle the response for 0x8 arrives.
        start_reset();
        rst  = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 30; c++) begin
            r = !done && pend && (pend_cnt == 0) && (pend_addr == 32'h8);
            drive_cycle(1'b1, r, 32'h100);
            if (r) begin
                done = 1'b1;
                check("redir8 out_valid next", out_valid, 0);
            end
        end
        check("redir8 redirect issued", done, 1);
        seen = 1'b0;
        foreach (pops[i]) if (pops[i].pc == 32'h8) seen = 1'b1;
        check("redir8 pc8 never output", seen, 0);
        check("redir8 pop count", pops.size() >= 3, 1);
        if (pops.size() >= 3) begin
            check("redir8 pop2 pc", pops[2].pc, 32'h100);
            check("redir8 pop2 instr", pops[2].instr, mem_word(32'h100));
        end

        // Unaligned redirect while waiting; the late response is dropped.
        start_reset();
        rst   = 1'b0;
        lat   = 4;
        done  = 1'b0;
        got   = 1'b0;
        for (int c = 0; c < 40; c++) begin
            r     = !done && pend && (pend_cnt == 3);
            rvnow = pend && (pend_cnt == 0);
            drive_cycle(1'b1, r, 32'h203);
            if (r) begin
                done = 1'b1;
                check("drop imem_req after redirect", imem_req, 0);
                check("drop out_valid after redirect", out_valid, 0);
            end else if (done && !got) begin
                if (rvnow) begin
                    got = 1'b1;
                    check("drop imem_req after data", imem_req, 1);
                    check("drop imem_addr after data", imem_addr, 32'h200);
                end else begin
                    check($sformatf("drop c%0d imem_req", c), imem_req, 0);
                end
            end
        end
        check("drop stale data seen", got, 1);
        check("drop pop count", pops.size() >= 1, 1);
        if (pops.size() >= 1) begin
            check("drop pop0 pc", pops[0].pc, 32'h200);
            check("drop pop0 instr", pops[0].instr, mem_word(32'h200));
        end

        // Reset with a request outstanding; its response lands after release.
        start_reset();
        rst = 1'b0;
        lat = 3;
        drive_cycle(1'b1, 1'b0, 32'h0);
        drive_cycle(1'b1, 1'b0, 32'h0);
        check("rstmid request outstanding", pend, 1);
        rst       = 1'b1;
        pend_addr = 32'hBAD0_0000;
        #1;
        check("rstmid imem_req in reset", imem_req, 0);
        check("rstmid out_valid in reset", out_valid, 0);
        drive_cycle(1'b1, 1'b0, 32'h0);
        rst = 1'b0;
        drive_cycle(1'b1, 1'b0, 32'h0);
        check("rstmid first imem_req", imem_req, 1);
        check("rstmid first imem_addr", imem_addr, RPC);
        got = 1'b0;
        for (int c = 0; c < 10; c++) begin
            fresh = pend && (pend_cnt == 0) && (pend_addr == RPC);
            drive_cycle(1'b0, 1'b0, 32'h0);
            if (!got) begin
                if (fresh) begin
                    got = 1'b1;
                    check("rstmid fresh out_valid", out_valid, 1);
                    check("rstmid fresh out_pc", out_pc, RPC);
                    check("rstmid fresh out_instr", out_instr, mem_word(RPC));
                end else begin
                    check($sformatf("rstmid c%0d out_valid", c), out_valid, 0);
                end
            end
        end
        check("rstmid fresh data seen", got, 1);

        // Fetch PC wraps past the top of the address space.
        start_reset();
        rst = 1'b0;
        drive_cycle(1'b1, 1'b1, 32'hFFFF_FFFF);
        check("wrap imem_req", imem_req, 1);
        check("wrap imem_addr", imem_addr, 32'hFFFF_FFFC);
        drive_cycle(1'b1, 1'b0, 32'h0);
        check("wrap next imem_addr", imem_addr, 32'h0000_0000);
        for (int c = 0; c < 8; c++) drive_cycle(1'b1, 1'b0, 32'h0);
        check("wrap pop count", pops.size() >= 2, 1);
        if (pops.size() >= 2) begin
            check("wrap pop0 pc", pops[0].pc, 32'hFFFF_FFFC);
            check("wrap pop1 pc", pops[1].pc, 32'h0000_0000);
            check("wrap pop1 instr", pops[1].instr, mem_word(32'h0));
        end

        // Randomized traffic against the reference model.
        start_reset();
        rst      = 1'b0;
        rand_lat = 1'b1;
        gnt_pct  = 70;
        for (int c = 0; c < 800; c++) begin
            r   = ($urandom_range(15) == 0);
            rpc = $urandom;
            rdy = ($urandom_range(9) < 7);
            drive_cycle(rdy, r, rpc);
            model_check(c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
